// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative multiply/divide
// producing HI/LO, behind a start/done handshake.
module alu_seq #(
    parameter int WSIZE = 8,
    parameter int HSIZE = WSIZE / 2,
    parameter int CNTW  = $clog2(WSIZE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WSIZE-1:0] a,
    input  logic [WSIZE-1:0] b,
    output logic [WSIZE-1:0] r,
    output logic [WSIZE-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_SLT  = 4'd4,
        OP_SLTU = 4'd5,
        OP_LUI  = 4'd6,
        OP_NOR  = 4'd7,
        OP_MULU = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIVU = 4'd10,
        OP_DIV  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic [WSIZE-1:0] MOST_NEG = {1'b1, {(WSIZE-1){1'b0}}};

    state_e state, state_next;

    logic [CNTW-1:0]  count;
    logic [WSIZE-1:0] acc;
    logic [WSIZE-1:0] lo;
    logic [WSIZE-1:0] opnd;
    logic             is_div;
    logic             is_signed;
    logic             neg_q;
    logic             neg_r;
    logic             div_ovf;

    logic             is_muldiv;
    logic             div_zero;
    logic             start_iter;
    logic             signed_op;
    logic [WSIZE-1:0] mag_a;
    logic [WSIZE-1:0] mag_b;

    logic [WSIZE-1:0] sc_r;
    logic [WSIZE-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_err;
    logic [WSIZE-1:0] sum;
    logic [WSIZE-1:0] diff;

    logic [WSIZE:0]     add_sum;
    logic [WSIZE:0]     trial;
    logic [WSIZE-1:0]   step_acc;
    logic [WSIZE-1:0]   step_lo;
    logic [2*WSIZE-1:0] prod_raw;
    logic [2*WSIZE-1:0] prod_fix;
    logic [WSIZE-1:0]   fin_r;
    logic [WSIZE-1:0]   fin_hi;
    logic               fin_ovf;

    // Divide by zero bypasses the iteration and completes like a single-cycle op.
    assign is_muldiv  = (op[3:2] == 2'b10);
    assign div_zero   = (op[3:1] == 3'b101) && (b == '0);
    assign start_iter = is_muldiv && !div_zero;
    assign signed_op  = op[0];
    assign mag_a      = (signed_op && a[WSIZE-1]) ? -a : a;
    assign mag_b      = (signed_op && b[WSIZE-1]) ? -b : b;

    assign zero = (r == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && start_iter) state_next = RUN;
            RUN:  if (count == CNTW'(WSIZE - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- single-cycle ops ----------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        sc_r   = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        sum    = a + b;
        diff   = a - b;
        case (op)
            OP_AND:  sc_r = a & b;
            OP_OR:   sc_r = a | b;
            OP_ADD: begin
                sc_r   = sum;
                sc_ovf = (a[WSIZE-1] == b[WSIZE-1]) && (sum[WSIZE-1] != a[WSIZE-1]);
            end
            OP_SUB: begin
                sc_r   = diff;
                sc_ovf = (a[WSIZE-1] != b[WSIZE-1]) && (diff[WSIZE-1] != a[WSIZE-1]);
            end
            OP_SLT:  sc_r = {{(WSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_r = {{(WSIZE-1){1'b0}}, (a < b)};
            OP_LUI:  sc_r = a << HSIZE;
            OP_NOR:  sc_r = ~(a | b);
            OP_DIVU, OP_DIV: begin
                // Only reached with b == 0.
                sc_r   = '1;
                sc_hi  = a;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // ---------------- iteration step ----------------
    always_comb begin
        add_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        trial   = {acc, lo[WSIZE-1]} - {1'b0, opnd};
        if (is_div) begin
            // Restoring division: keep the partial remainder when the trial goes negative.
            if (trial[WSIZE]) begin
                step_acc = {acc[WSIZE-2:0], lo[WSIZE-1]};
                step_lo  = {lo[WSIZE-2:0], 1'b0};
            end else begin
                step_acc = trial[WSIZE-1:0];
                step_lo  = {lo[WSIZE-2:0], 1'b1};
            end
        end else begin
            step_acc = add_sum[WSIZE:1];
            step_lo  = {add_sum[0], lo[WSIZE-1:1]};
        end
    end

    // ---------------- sign correction ----------------
    always_comb begin
        prod_raw = {acc, lo};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        if (is_div) begin
            fin_r   = neg_q ? -lo : lo;
            fin_hi  = neg_r ? -acc : acc;
            fin_ovf = div_ovf;
        end else begin
            fin_hi  = prod_fix[2*WSIZE-1:WSIZE];
            fin_r   = prod_fix[WSIZE-1:0];
            fin_ovf = is_signed ? (fin_hi != {WSIZE{fin_r[WSIZE-1]}}) : (fin_hi != '0);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            acc       <= '0;
            lo        <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_ovf   <= 1'b0;
            r         <= '0;
            hi        <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (start_iter) begin
                            count     <= '0;
                            acc       <= '0;
                            lo        <= mag_a;
                            opnd      <= mag_b;
                            is_div    <= op[1];
                            is_signed <= signed_op;
                            neg_q     <= signed_op && (a[WSIZE-1] ^ b[WSIZE-1]);
                            neg_r     <= signed_op && a[WSIZE-1];
                            div_ovf   <= (op == OP_DIV) && (a == MOST_NEG) && (b == '1);
                        end else begin
                            r    <= sc_r;
                            hi   <= sc_hi;
                            ovf  <= sc_ovf;
                            err  <= sc_err;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_acc;
                    lo    <= step_lo;
                    count <= count + 1'b1;
                end
                FIX: begin
                    r    <= fin_r;
                    hi   <= fin_hi;
                    ovf  <= fin_ovf;
                    err  <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
